// File: rtl/vospi_rx_master.sv
// FLIR Lepton VoSPI receive master.
// Holds CS high for a resync period, then clocks continuous packets in SPI
// mode 3. Discard packets and out-of-sequence packets are dropped. The 4-byte
// header of each accepted packet is stripped, and its payload bytes are
// streamed out one strobe per byte.
module vospi_rx_master #(
  parameter int packet_bytes_p     = 164,
  parameter int frame_packets_p    = 60,
  parameter int sync_idle_cycles_p = 7_400_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       cs_o,
  output logic [7:0] data_o,
  output logic       valid_o
);

  localparam int sync_w = $clog2(sync_idle_cycles_p + 1);
  localparam int byte_w = $clog2(packet_bytes_p);
  localparam int pkt_w  = $clog2(frame_packets_p + 1);

  localparam logic [1:0] st_idle    = 2'd0;
  localparam logic [1:0] st_sync    = 2'd1;
  localparam logic [1:0] st_capture = 2'd2;

  localparam logic [sync_w-1:0] sync_last  = sync_w'(sync_idle_cycles_p - 1);
  localparam logic [byte_w-1:0] byte_last  = byte_w'(packet_bytes_p - 1);
  localparam logic [byte_w-1:0] first_data = byte_w'(4);
  localparam logic [pkt_w-1:0]  pkt_last   = pkt_w'(frame_packets_p - 1);

  logic [1:0]        state;
  logic [sync_w-1:0] sync_count;
  logic              sclk;
  logic [2:0]        bit_count;
  logic [byte_w-1:0] byte_count;
  logic [6:0]        shift;
  logic [3:0]        id_hi;
  logic              pkt_ok;
  logic              pkt_bad;
  logic [pkt_w-1:0]  expected;
  logic              sample;
  logic [7:0]        full_byte;

  // Sample on the edge where the SPI clock register rises; the byte being
  // completed includes the bit arriving on this edge.
  always_comb begin
    sample    = (state == st_capture) && !sclk;
    full_byte = {shift, miso_i};
  end

  assign cs_o   = (state != st_capture);
  assign sclk_o = sclk;

  // Main sequencer: resync timer, bit/byte framing, header decode, forwarding.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= st_idle;
      sync_count <= '0;
      sclk       <= 1'b1;
      bit_count  <= '0;
      byte_count <= '0;
      shift      <= '0;
      id_hi      <= '0;
      pkt_ok     <= 1'b0;
      pkt_bad    <= 1'b0;
      expected   <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        st_idle: begin
          sclk <= 1'b1;
          if (start_i) begin
            state      <= st_sync;
            sync_count <= '0;
          end
        end
        st_sync: begin
          sclk <= 1'b1;
          if (sync_count == sync_last) begin
            state      <= st_capture;
            sync_count <= '0;
            bit_count  <= '0;
            byte_count <= '0;
            pkt_ok     <= 1'b0;
            pkt_bad    <= 1'b0;
            expected   <= '0;
          end else begin
            sync_count <= sync_count + sync_w'(1);
          end
        end
        st_capture: begin
          sclk <= ~sclk;
          if (sample) begin
            shift     <= full_byte[6:0];
            bit_count <= bit_count + 3'd1;
            if (bit_count == 3'd7) begin
              if (byte_count == '0) begin
                id_hi   <= full_byte[3:0];
                pkt_ok  <= 1'b0;
                pkt_bad <= 1'b0;
              end else if (byte_count == byte_w'(1)) begin
                if (id_hi != 4'hF) begin
                  if ({id_hi, full_byte} == 12'(expected)) pkt_ok <= 1'b1;
                  else pkt_bad <= 1'b1;
                end
              end else if (byte_count >= first_data && pkt_ok) begin
                data_o  <= full_byte;
                valid_o <= 1'b1;
              end
              if (byte_count == byte_last) begin
                byte_count <= '0;
                if (pkt_ok) begin
                  expected <= (expected == pkt_last) ? '0 : expected + pkt_w'(1);
                end
                if (pkt_bad) begin
                  state      <= st_sync;
                  sync_count <= '0;
                  expected   <= '0;
                end
              end else begin
                byte_count <= byte_count + byte_w'(1);
              end
            end
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_vospi_rx_master.sv
// Testbench for vospi_rx_master: a camera model serves queued packets
// (discard filler when idle), a collector records forwarded bytes, and a
// packet-level reference model predicts the expected byte stream.
// Packet length is shortened so a full 60-row frame stays short in cycles.
module tb_vospi_rx_master;

  localparam int PB   = 20;
  localparam int FP   = 60;
  localparam int SYNC = 10;
  localparam int PAY  = PB - 4;
  localparam int PIX  = PAY / 2;
  localparam int PKT_CYC = PB * 16;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       miso_i;
  logic       sclk_o;
  logic       cs_o;
  logic [7:0] data_o;
  logic       valid_o;

  vospi_rx_master #(
    .packet_bytes_p    (PB),
    .frame_packets_p   (FP),
    .sync_idle_cycles_p(SYNC)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .start_i(start_i),
    .miso_i (miso_i),
    .sclk_o (sclk_o),
    .cs_o   (cs_o),
    .data_o (data_o),
    .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pkt_buf[$];
  logic [7:0] cur_byte = 8'h00;
  int bit_idx = 0;
  int model_n = 0;
  int cs_run = 0;
  int last_run = 0;
  int sync_events = 0;
  logic [15:0] img [FP][PIX];

  // Camera model: shift out the next bit after each falling SPI clock edge.
  always @(negedge sclk_o) begin
    if (cs_o === 1'b0) begin
      if (bit_idx == 0) begin
        if (tx_q.size() == 0)
          for (int i = 0; i < PB; i++) tx_q.push_back(8'hFF);
        cur_byte = tx_q.pop_front();
      end
      miso_i  = cur_byte[7 - bit_idx];
      bit_idx = (bit_idx + 1) % 8;
    end
  end

  // A deselect realigns the camera to a packet boundary.
  always @(posedge cs_o) bit_idx = 0;

  // Collect forwarded bytes and measure chip-select high periods.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) rx_q.push_back(data_o);
    if (cs_o === 1'b1) cs_run++;
    else if (cs_run != 0) begin
      last_run = cs_run;
      cs_run = 0;
      sync_events++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic make_packet(input int num, input bit zero_fill);
    pkt_buf.delete();
    pkt_buf.push_back({4'($urandom_range(0, 15)), 4'(num >> 8)});
    pkt_buf.push_back(8'(num));
    pkt_buf.push_back(8'($urandom));
    pkt_buf.push_back(8'($urandom));
    for (int i = 0; i < PAY; i++) pkt_buf.push_back(zero_fill ? 8'h00 : 8'($urandom));
  endtask

  // Reference model: sequencing by packet number with discard and resync.
  task automatic send_packet();
    int id_lo;
    int num;
    foreach (pkt_buf[i]) tx_q.push_back(pkt_buf[i]);
    id_lo = int'(pkt_buf[0][3:0]);
    num   = id_lo * 256 + int'(pkt_buf[1]);
    if (id_lo == 15) begin
    end else if (num == model_n) begin
      for (int i = 4; i < PB; i++) exp_q.push_back(pkt_buf[i]);
      model_n = (model_n + 1) % FP;
    end else begin
      model_n = 0;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    start_i = 1'b0;
    miso_i  = 1'b1;
    wait_cycles(3);
    total++; if (cs_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_cs got=%b exp=1", cs_o); end
    total++; if (sclk_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_sclk got=%b exp=1", sclk_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (data_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h exp=00", data_o); end
    reset_i = 1'b0;
    wait_cycles(5);
    total++; if (cs_o !== 1'b1) begin bad++; $display("[TB] FAIL idle_cs got=%b exp=1", cs_o); end
  endtask

  task automatic test_sync_start();
    int count;
    logic prev;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    model_n = 0;
    count = 0;
    while (cs_o === 1'b1 && count < 100) begin
      count++;
      start_i = (count == 3);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    total++; if (count != SYNC) begin bad++; $display("[TB] FAIL sync_len got=%0d exp=%0d", count, SYNC); end
    prev = sclk_o;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      total++;
      if (sclk_o !== ~prev) begin bad++; $display("[TB] FAIL sclk_toggle got=%b exp=%b", sclk_o, ~prev); end
      prev = sclk_o;
    end
    total++; if (cs_o !== 1'b0) begin bad++; $display("[TB] FAIL capture_cs got=%b exp=0", cs_o); end
  endtask

  task automatic test_discard();
    rx_q.delete();
    exp_q.delete();
    pkt_buf.delete();
    pkt_buf.push_back(8'h0F); pkt_buf.push_back(8'h00);
    pkt_buf.push_back(8'h0F); pkt_buf.push_back(8'h00);
    for (int i = 0; i < PAY; i++) pkt_buf.push_back(8'h00);
    send_packet();
    wait_cycles(3 * PKT_CYC);
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL discard_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
  endtask

  task automatic test_frame();
    int errs;
    rx_q.delete();
    exp_q.delete();
    for (int p = 0; p < FP; p++) begin
      make_packet(p, 1'b0);
      for (int k = 0; k < PIX; k++) begin
        img[p][k] = 16'($urandom);
        pkt_buf[4 + 2 * k] = img[p][k][15:8];
        pkt_buf[5 + 2 * k] = img[p][k][7:0];
      end
      send_packet();
    end
    wait_cycles((FP + 2) * PKT_CYC);
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL frame_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    errs = 0;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++;
        if (errs < 5) $display("[TB] FAIL frame_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]);
        errs++;
      end
    end
    errs = 0;
    for (int p = 0; p < FP; p++)
      for (int k = 0; k < PIX; k++)
        if (rx_q.size() > 2 * (p * PIX + k) + 1)
          if ({rx_q[2 * (p * PIX + k)], rx_q[2 * (p * PIX + k) + 1]} !== img[p][k]) errs++;
    total++; if (errs != 0 || rx_q.size() != FP * PAY) begin bad++; $display("[TB] FAIL image_pixels got=%0d_bad exp=0_bad", errs); end
  endtask

  task automatic test_wrap();
    logic prev;
    rx_q.delete();
    exp_q.delete();
    make_packet(12'hF00 | $urandom_range(0, 255), 1'b0);
    send_packet();
    make_packet(model_n, 1'b0);
    send_packet();
    wait_cycles(4 * PKT_CYC);
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL wrap_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL wrap_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    total++; if (cs_o !== 1'b0) begin bad++; $display("[TB] FAIL wrap_cs got=%b exp=0", cs_o); end
    prev = sclk_o;
    @(negedge clk_i);
    total++; if (sclk_o !== ~prev) begin bad++; $display("[TB] FAIL wrap_sclk got=%b exp=%b", sclk_o, ~prev); end
  endtask

  task automatic test_resync();
    int ev0;
    rx_q.delete();
    exp_q.delete();
    ev0 = sync_events;
    make_packet(model_n, 1'b0); send_packet();
    make_packet(model_n, 1'b0); send_packet();
    make_packet(model_n + 2, 1'b0); send_packet();
    make_packet(model_n, 1'b0); send_packet();
    wait_cycles(6 * PKT_CYC + 50);
    total++; if (sync_events != ev0 + 1) begin bad++; $display("[TB] FAIL resync_events got=%0d exp=%0d", sync_events - ev0, 1); end
    total++; if (last_run != SYNC) begin bad++; $display("[TB] FAIL resync_len got=%0d exp=%0d", last_run, SYNC); end
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL resync_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL resync_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    int guard;
    rx_q.delete();
    make_packet(model_n, 1'b0);
    foreach (pkt_buf[i]) tx_q.push_back(pkt_buf[i]);
    guard = 0;
    while (rx_q.size() < 3 && guard < 4 * PKT_CYC) begin
      guard++;
      @(negedge clk_i);
    end
    total++; if (rx_q.size() < 3) begin bad++; $display("[TB] FAIL midpkt_wait got=%0d exp=3", rx_q.size()); end
    wait_cycles(5);
    reset_i = 1'b1;
    @(negedge clk_i);
    total++; if (cs_o !== 1'b1) begin bad++; $display("[TB] FAIL midrst_cs got=%b exp=1", cs_o); end
    total++; if (sclk_o !== 1'b1) begin bad++; $display("[TB] FAIL midrst_sclk got=%b exp=1", sclk_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got=%b exp=0", valid_o); end
    total++; if (data_o !== 8'h00) begin bad++; $display("[TB] FAIL midrst_data got=%h exp=00", data_o); end
    n0 = rx_q.size();
    wait_cycles(4);
    reset_i = 1'b0;
    tx_q.delete();
    wait_cycles(40);
    total++; if (rx_q.size() != n0) begin bad++; $display("[TB] FAIL idle_novalid got=%0d exp=%0d", rx_q.size(), n0); end
    total++; if (cs_o !== 1'b1 || sclk_o !== 1'b1) begin bad++; $display("[TB] FAIL idle_lines got=%b%b exp=11", cs_o, sclk_o); end
  endtask

  initial begin
    test_reset();
    test_sync_start();
    test_discard();
    test_frame();
    test_wrap();
    test_resync();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
